// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end: data width, the canonical
// NOP and the {pc, inst} record carried through the fetch buffer.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: DEPTH x {pc, inst} with a single-cycle flush.
// The head entry is read straight out of the storage registers, so whatever
// was pushed on the last edge is visible on head_o in the following cycle.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t entry_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];

   logic push_eff;
   logic pop_eff;

   // Flush wins over everything; a pop on an empty buffer is ignored.
   assign push_eff = push_i && !flush_i;
   assign pop_eff  = pop_i && !flush_i && !empty_o;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state; reset empties the buffer without touching the storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count_q.
   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wr_ptr_q] <= entry_i;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational imem,
// queues {pc, inst} pairs for decode and applies EX redirects, which flush
// every wrong-path entry and restart fetch at the word-aligned target.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_inst,
   input  logic            halt,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc
);

   localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            fetch_en;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // A full buffer can still take a fetch when decode frees the head slot.
   assign pop        = out_valid && out_ready;
   assign fetch_en   = !halt && !redirect_valid && (!fifo_full || pop);
   assign imem_addr  = pc_q;
   assign push_entry = '{pc: pc_q, inst: imem_inst};

   // Redirect overrides halt and fetch; +4 wraps silently at 2^32.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & WORD_MASK;
      end else if (fetch_en) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // PC register; low two bits are forced clear so the PC stays aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC & WORD_MASK;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fetch_en),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .entry_i (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

   // Empty buffer presents a NOP at PC 0 so decode never sees stale data.
   assign out_valid = !fifo_empty;
   assign out_inst  = fifo_empty ? NOP_INST : head.inst;
   assign out_pc    = fifo_empty ? '0       : head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural imem answers the fetch address,
// expected {pc, inst} pairs are queued as the scenario is set up and retired
// whenever decode accepts the head.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   logic [31:0] prog [14] = '{
      32'h0050_0093, 32'h0030_8113, 32'h0070_0193, 32'h4020_8233,
      32'h0020_f2b3, 32'h0020_e333, 32'h0020_c3b3, 32'h0020_9433,
      32'h0020_d4b3, 32'h0011_2023, 32'h0001_2583, 32'h0000_0013,
      32'h0000_006f, 32'h0010_0513
   };

   function automatic logic [31:0] rom(input logic [31:0] addr);
      int idx;
      idx = int'(addr >> 2);
      if (addr < 32'd56) return prog[idx];
      return NOP;
   endfunction

   assign imem_inst = rom(imem_addr);

   fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sbp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = rom(pc);
      sb.push_back(e);
   endtask

   // Retire the head against the scoreboard if decode takes it on the coming
   // edge (pops in a redirect cycle are discarded), then advance one cycle.
   task automatic step();
      exp_t e;
      if (out_valid === 1'b1 && out_ready && !redirect_valid) begin
         vectors++;
         assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL sb_unexpected: observed pop pc %h expected no entry", out_pc);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_inst", out_inst, e.inst);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_inst", out_inst, NOP);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);

      // 1: streaming with decode always ready, no bubbles
      out_ready = 1'b1;
      rst_n     = 1'b1;
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_valid0", out_valid, 1'b0);
      for (int i = 0; i < 10; i++) sbp(32'(i * 4));
      step();
      for (int i = 0; i < 10; i++) begin
         chk("t1_valid", out_valid, 1'b1);
         step();
      end
      chk("t1_sb_drained", 32'(sb.size()), 32'h0);

      // 2: decode stalled for 5 cycles after reset
      rst_n     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("t2_async_valid", out_valid, 1'b0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step();
      chk("t2_addr_hold", imem_addr, 32'h8);
      chk("t2_inst_hold", out_inst, 32'h0050_0093);
      chk("t2_pc_hold", out_pc, 32'h0);
      chk("t2_valid_hold", out_valid, 1'b1);
      out_ready = 1'b1;
      sbp(32'h0);
      sbp(32'h4);
      sbp(32'h8);
      repeat (3) step();
      chk("t2_sb_drained", 32'(sb.size()), 32'h0);
      chk("t2_addr_after", imem_addr, 32'd20);
      chk("t2_head_after", out_pc, 32'd12);

      // 3: redirect to 0x34 while the buffer is full
      redirect_valid = 1'b1;
      redirect_pc    = 32'h34;
      step();
      redirect_valid = 1'b0;
      chk("t3_valid_gap", out_valid, 1'b0);
      chk("t3_addr", imem_addr, 32'h34);
      sbp(32'h34);
      step();
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_pc", out_pc, 32'h34);
      chk("t3_inst", out_inst, 32'h0010_0513);
      step();

      // 4: misaligned redirect target is word aligned
      redirect_valid = 1'b1;
      redirect_pc    = 32'h37;
      step();
      redirect_valid = 1'b0;
      chk("t4_valid_gap", out_valid, 1'b0);
      chk("t4_addr", imem_addr, 32'h34);
      sbp(32'h34);
      step();
      chk("t4_pc", out_pc, 32'h34);
      step();
      chk("t4_sb_drained", 32'(sb.size()), 32'h0);

      // 5: halt with two buffered entries; buffer drains, pc frozen
      rst_n     = 1'b0;
      out_ready = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step();
      halt      = 1'b1;
      out_ready = 1'b1;
      sbp(32'h0);
      sbp(32'h4);
      repeat (2) step();
      chk("t5_valid_empty", out_valid, 1'b0);
      chk("t5_inst_nop", out_inst, NOP);
      chk("t5_pc_zero", out_pc, 32'h0);
      chk("t5_addr_held", imem_addr, 32'h8);
      step();
      chk("t5_addr_still", imem_addr, 32'h8);
      halt = 1'b0;
      sbp(32'h8);
      step();
      chk("t5_resume_pc", out_pc, 32'h8);
      step();
      chk("t5_sb_drained", 32'(sb.size()), 32'h0);

      // 6: asynchronous reset mid-stream
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", out_valid, 1'b0);
      chk("t6_async_pc", out_pc, 32'h0);
      chk("t6_async_addr", imem_addr, 32'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      sbp(32'h0);
      chk("t6_valid0", out_valid, 1'b0);
      step();
      chk("t6_valid1", out_valid, 1'b1);
      chk("t6_first_pc", out_pc, 32'h0);
      step();

      // 7: PC wraps from the top of the address space to 0
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
      sbp(32'hFFFF_FFFC);
      step();
      chk("t7_addr_wrap", imem_addr, 32'h0);
      sbp(32'h0);
      repeat (2) step();
      out_ready = 1'b0;
      chk("t7_sb_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
